// File: rtl/task_queue_if.sv
// Valid/ready task word channel. The master drives data/valid, the slave
// drives ready. Used both for the decode-stage input and the balancer output.
interface task_queue_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/task_queue.sv
// Elastic task buffer feeding the PE load balancer.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_EMPTY   | output register holds no task, task_valid=0
//   ST_PRESENT | task_data offered to the balancer, task_valid=1
//   ST_HOLD    | task accepted; task_data frozen until ready goes low then high
//
// After the balancer accepts a word, it samples task_data several cycles
// later. With HOLD_EN set, the queue keeps that word in the output register
// until task_ready has been seen low and then high again (the re-arm).
// A word written into empty storage goes straight to the output register.
// This bypass is only taken when storage is empty, so FIFO order holds.
module task_queue #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int AF_THRESH  = 12,
   parameter int HOLD_EN    = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   task_queue_if.slave                in_if,
   task_queue_if.master               task_if,
   output logic [$clog2(DEPTH+2)-1:0] count,
   output logic                       almost_full
);

   localparam int PW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH + 1);
   localparam int CW = $clog2(DEPTH + 2);

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PRESENT = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic                  seen_low, seen_low_nxt;
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [OW-1:0]         occ, occ_nxt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] task_data_q;

   logic st_full, st_empty;
   logic push, wr_en, pop;
   logic load_head, load_bypass;

   assign st_full     = (occ == OW'(DEPTH));
   assign st_empty    = (occ == '0);
   assign in_if.ready = !st_full && !flush;
   assign push        = in_if.valid && in_if.ready;

   assign task_if.valid = (state == ST_PRESENT);
   assign task_if.data  = task_data_q;

   // Output FSM next state: decide whether the output register is reloaded and from where.
   always_comb begin
      state_nxt    = state;
      seen_low_nxt = seen_low;
      load_head    = 1'b0;
      load_bypass  = 1'b0;
      if (flush) begin
         state_nxt    = ST_EMPTY;
         seen_low_nxt = 1'b0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (!st_empty) begin
                  load_head = 1'b1;
                  state_nxt = ST_PRESENT;
               end else if (push) begin
                  load_bypass = 1'b1;
                  state_nxt   = ST_PRESENT;
               end
            end
            ST_PRESENT: begin
               if (task_if.ready) begin
                  if (HOLD_EN != 0) begin
                     state_nxt    = ST_HOLD;
                     seen_low_nxt = 1'b0;
                  end else if (!st_empty) begin
                     load_head = 1'b1;
                  end else if (push) begin
                     load_bypass = 1'b1;
                  end else begin
                     state_nxt = ST_EMPTY;
                  end
               end
            end
            ST_HOLD: begin
               if (!task_if.ready) begin
                  seen_low_nxt = 1'b1;
               end else if (seen_low) begin
                  seen_low_nxt = 1'b0;
                  if (!st_empty) begin
                     load_head = 1'b1;
                     state_nxt = ST_PRESENT;
                  end else if (push) begin
                     load_bypass = 1'b1;
                     state_nxt   = ST_PRESENT;
                  end else begin
                     state_nxt = ST_EMPTY;
                  end
               end
            end
            default: begin
               state_nxt    = ST_EMPTY;
               seen_low_nxt = 1'b0;
            end
         endcase
      end
   end

   // Storage bookkeeping: a bypassed push never touches storage.
   always_comb begin
      pop   = load_head;
      wr_en = push && !load_bypass;
      case ({wr_en, pop})
         2'b10:   occ_nxt = occ + OW'(1);
         2'b01:   occ_nxt = occ - OW'(1);
         default: occ_nxt = occ;
      endcase
   end

   // Control state, pointers and registered status; flush clears all but task_data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_EMPTY;
         seen_low    <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         occ         <= '0;
         count       <= '0;
         almost_full <= 1'b0;
      end else if (flush) begin
         state       <= ST_EMPTY;
         seen_low    <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         occ         <= '0;
         count       <= '0;
         almost_full <= 1'b0;
      end else begin
         state       <= state_nxt;
         seen_low    <= seen_low_nxt;
         occ         <= occ_nxt;
         count       <= CW'(occ_nxt) + CW'(state_nxt == ST_PRESENT);
         almost_full <= (occ_nxt >= OW'(AF_THRESH));
         if (wr_en) wr_ptr <= wr_ptr + PW'(1);
         if (pop)   rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en) mem[wr_ptr] <= in_if.data;
   end

   // Output register: only reset clears it, flush leaves the last word visible.
   always_ff @(posedge clk) begin
      if (!rst_n)
         task_data_q <= '0;
      else if (load_bypass)
         task_data_q <= in_if.data;
      else if (load_head)
         task_data_q <= mem[rd_ptr];
   end

endmodule

// File: tb/tb_task_queue.sv
// Directed bench: dut_a runs with hold-after-accept, dut_b as plain FWFT.
module tb_task_queue;

   logic clk = 1'b0;
   logic rst_n;
   logic flush_a, flush_b;
   logic [4:0] count_a, count_b;
   logic af_a, af_b;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   task_queue_if #(.DATA_WIDTH(32)) ia ();
   task_queue_if #(.DATA_WIDTH(32)) ta ();
   task_queue_if #(.DATA_WIDTH(32)) ib ();
   task_queue_if #(.DATA_WIDTH(32)) tb_o ();

   task_queue #(.DATA_WIDTH(32), .DEPTH(16), .AF_THRESH(12), .HOLD_EN(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .flush(flush_a), .in_if(ia.slave), .task_if(ta.master),
      .count(count_a), .almost_full(af_a));

   task_queue #(.DATA_WIDTH(32), .DEPTH(16), .AF_THRESH(12), .HOLD_EN(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush_b), .in_if(ib.slave), .task_if(tb_o.master),
      .count(count_b), .almost_full(af_b));

   task tick();
      @(posedge clk);
      #1;
   endtask

   task test_reset();
      rst_n = 1'b0; flush_a = 0; flush_b = 0;
      ia.valid = 0; ia.data = '0; ta.ready = 0;
      ib.valid = 0; ib.data = '0; tb_o.ready = 0;
      tick(); tick();
      rst_n = 1'b1;
      #1;
      checks++; if (ta.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ta.valid); end
      checks++; if (ta.data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", ta.data); end
      checks++; if (count_a !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_a); end
      checks++; if (af_a !== 1'b0) begin errors++; $display("FAIL reset_af got %b exp 0", af_a); end
      checks++; if (ia.ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", ia.ready); end
   endtask

   task test_single();
      ia.data = 32'hA5; ia.valid = 1;
      tick();
      ia.valid = 0;
      checks++; if (ta.valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", ta.valid); end
      checks++; if (ta.data !== 32'hA5) begin errors++; $display("FAIL single_data got %h exp a5", ta.data); end
      checks++; if (count_a !== 5'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count_a); end
      ta.ready = 1; tick();
      checks++; if (ta.valid !== 1'b0 || ta.data !== 32'hA5 || count_a !== 5'd0) begin
         errors++; $display("FAIL single_hold got v=%b d=%h c=%0d exp v=0 d=a5 c=0", ta.valid, ta.data, count_a); end
      ta.ready = 0; tick();
      ta.ready = 1; tick();
      ta.ready = 0;
      checks++; if (ta.valid !== 1'b0 || dut_a.state !== 2'd0) begin
         errors++; $display("FAIL single_rearm_empty got v=%b st=%0d exp v=0 st=0", ta.valid, dut_a.state); end
   endtask

   task test_hold();
      ia.valid = 1; ia.data = 32'h11; tick();
      ia.data = 32'h22; tick();
      ia.valid = 0;
      checks++; if (ta.data !== 32'h11 || ta.valid !== 1'b1 || count_a !== 5'd2) begin
         errors++; $display("FAIL hold_pre got v=%b d=%h c=%0d exp v=1 d=11 c=2", ta.valid, ta.data, count_a); end
      ta.ready = 1; tick();
      checks++; if (ta.valid !== 1'b0 || ta.data !== 32'h11 || count_a !== 5'd1) begin
         errors++; $display("FAIL hold_accept got v=%b d=%h c=%0d exp v=0 d=11 c=1", ta.valid, ta.data, count_a); end
      tick();
      checks++; if (ta.valid !== 1'b0 || ta.data !== 32'h11) begin
         errors++; $display("FAIL hold_ready_high got v=%b d=%h exp v=0 d=11", ta.valid, ta.data); end
      ta.ready = 0; tick();
      checks++; if (ta.valid !== 1'b0 || ta.data !== 32'h11) begin
         errors++; $display("FAIL hold_ready_low got v=%b d=%h exp v=0 d=11", ta.valid, ta.data); end
      ta.ready = 1; tick();
      ta.ready = 0;
      checks++; if (ta.valid !== 1'b1 || ta.data !== 32'h22 || count_a !== 5'd1) begin
         errors++; $display("FAIL hold_rearm got v=%b d=%h c=%0d exp v=1 d=22 c=1", ta.valid, ta.data, count_a); end
      ta.ready = 1; tick();
      ta.ready = 0; tick();
      ta.ready = 1; tick();
      ta.ready = 0;
      checks++; if (ta.valid !== 1'b0 || count_a !== 5'd0) begin
         errors++; $display("FAIL hold_drain got v=%b c=%0d exp v=0 c=0", ta.valid, count_a); end
   endtask

   task test_fill_flush();
      ta.ready = 0;
      for (int i = 0; i < 17; i++) begin
         ia.valid = 1; ia.data = 32'h100 + i;
         tick();
         checks++; if (count_a !== 5'(i + 1) || af_a !== (i >= 12)) begin
            errors++; $display("FAIL fill_%0d got c=%0d af=%b exp c=%0d af=%b", i, count_a, af_a, i + 1, (i >= 12)); end
      end
      checks++; if (ia.ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b exp 0", ia.ready); end
      ia.data = 32'hDEAD; tick();
      ia.valid = 0;
      checks++; if (count_a !== 5'd17 || ta.data !== 32'h100) begin
         errors++; $display("FAIL fill_overpush got c=%0d d=%h exp c=17 d=100", count_a, ta.data); end
      flush_a = 1; #1;
      checks++; if (ia.ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", ia.ready); end
      tick();
      flush_a = 0;
      checks++; if (count_a !== 5'd0 || ta.valid !== 1'b0 || af_a !== 1'b0 || ta.data !== 32'h100) begin
         errors++; $display("FAIL fill_flush got c=%0d v=%b af=%b d=%h exp c=0 v=0 af=0 d=100", count_a, ta.valid, af_a, ta.data); end
   endtask

   task test_stream();
      tb_o.ready = 1;
      for (int i = 0; i < 40; i++) begin
         ib.valid = 1; ib.data = i;
         tick();
         checks++; if (tb_o.valid !== 1'b1 || tb_o.data !== 32'(i) || count_b !== 5'd1) begin
            errors++; $display("FAIL stream_%0d got v=%b d=%h c=%0d exp v=1 d=%h c=1", i, tb_o.valid, tb_o.data, count_b, i); end
      end
      ib.valid = 0; tick();
      checks++; if (tb_o.valid !== 1'b0 || count_b !== 5'd0) begin
         errors++; $display("FAIL stream_end got v=%b c=%0d exp v=0 c=0", tb_o.valid, count_b); end
   endtask

   task test_back_to_back_wrap();
      tb_o.ready = 0;
      for (int k = 0; k < 6; k++) begin
         ib.valid = 1; ib.data = 32'h200 + k; tick();
      end
      checks++; if (count_b !== 5'd6 || tb_o.data !== 32'h200) begin
         errors++; $display("FAIL wrap_prefill got c=%0d d=%h exp c=6 d=200", count_b, tb_o.data); end
      tb_o.ready = 1;
      for (int j = 0; j < 16; j++) begin
         ib.data = 32'h206 + j; tick();
         checks++; if (tb_o.data !== 32'h201 + j || count_b !== 5'd6) begin
            errors++; $display("FAIL wrap_pp_%0d got d=%h c=%0d exp d=%h c=6", j, tb_o.data, count_b, 32'h201 + j); end
      end
      ib.valid = 0;
      for (int j = 0; j < 5; j++) begin
         tick();
         checks++; if (tb_o.data !== 32'h211 + j || tb_o.valid !== 1'b1) begin
            errors++; $display("FAIL wrap_drain_%0d got v=%b d=%h exp v=1 d=%h", j, tb_o.valid, tb_o.data, 32'h211 + j); end
      end
      tick();
      tb_o.ready = 0;
      checks++; if (tb_o.valid !== 1'b0 || count_b !== 5'd0) begin
         errors++; $display("FAIL wrap_end got v=%b c=%0d exp v=0 c=0", tb_o.valid, count_b); end
   endtask

   task load_hold_a();
      ta.ready = 0;
      for (int k = 0; k < 4; k++) begin
         ia.valid = 1; ia.data = 32'h300 + k; tick();
      end
      ia.valid = 0;
      ta.ready = 1; tick();
   endtask

   task test_flush_hold();
      load_hold_a();
      checks++; if (dut_a.state !== 2'd2 || count_a !== 5'd3 || ta.data !== 32'h300) begin
         errors++; $display("FAIL fh_setup got st=%0d c=%0d d=%h exp st=2 c=3 d=300", dut_a.state, count_a, ta.data); end
      flush_a = 1; ia.valid = 1; ia.data = 32'hBAD; tick();
      flush_a = 0; ia.valid = 0;
      checks++; if (dut_a.state !== 2'd0 || count_a !== 5'd0 || ta.valid !== 1'b0 || ta.data !== 32'h300) begin
         errors++; $display("FAIL fh_flush got st=%0d c=%0d v=%b d=%h exp st=0 c=0 v=0 d=300", dut_a.state, count_a, ta.valid, ta.data); end
      tick();
      checks++; if (ta.valid !== 1'b0 || count_a !== 5'd0) begin
         errors++; $display("FAIL fh_no_push got v=%b c=%0d exp v=0 c=0", ta.valid, count_a); end
      load_hold_a();
      rst_n = 0; tick();
      rst_n = 1; ta.ready = 0;
      checks++; if (dut_a.state !== 2'd0 || count_a !== 5'd0 || ta.valid !== 1'b0 || ta.data !== 32'h0) begin
         errors++; $display("FAIL fh_reset got st=%0d c=%0d v=%b d=%h exp st=0 c=0 v=0 d=0", dut_a.state, count_a, ta.valid, ta.data); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_hold();
      test_fill_flush();
      test_stream();
      test_back_to_back_wrap();
      test_flush_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
